// File: rtl/ins_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: PC/instruction widths and the FIFO entry.
package ins_fetch_pkg;
  localparam int PC_W  = 32;
  localparam int INS_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } fetch_entry_t;
endpackage

// File: rtl/ins_fetch_unit_if.sv
// Fetch unit bus: instruction memory port, decode handshake and execute redirect.
interface ins_fetch_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_ins;
  logic [31:0]       out_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic              misalign_err;

  modport master (
    output im_addr, out_valid, out_ins, out_pc, misalign_err,
    input  im_data, out_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  im_addr, out_valid, out_ins, out_pc, misalign_err,
    output im_data, out_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/ins_fetch_unit_fifo.sv
// DEPTH-entry synchronous fetch FIFO; flush dominates push and pop.
module ins_fetch_fifo
  import ins_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; stale slots are never visible past count.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: PC sequencing, fetch FIFO control and redirect handling.
// Optional feature macro IFU_MISALIGN_CHK_EN: misaligned redirect sets a sticky error and stops fetch.
module ins_fetch_unit
  import ins_fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic               clk,
  input logic               rst,
  ins_fetch_unit_if.master  bus
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]  fetch_pc;
  fetch_entry_t     head, last, push_entry;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop, stopped;

  assign pop  = !empty && bus.out_ready;
  assign push = !bus.redirect_valid && !bus.halt && !stopped && (!full || pop);

  assign push_entry.pc  = fetch_pc;
  assign push_entry.ins = INS_W'(bus.im_data);

  ins_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (rst)                     fetch_pc <= RESET_PC;
    else if (bus.redirect_valid) fetch_pc <= bus.redirect_pc & ~32'h3;
    else if (push)               fetch_pc <= fetch_pc + PC_STEP;
  end

  // Remembers the last presented head so outputs hold while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst)         last <= '0;
    else if (!empty) last <= head;
  end

  assign bus.im_addr   = fetch_pc[ADDR_W+1:2];
  assign bus.out_valid = !empty;
  assign bus.out_pc    = empty ? last.pc : head.pc;
  assign bus.out_ins   = DATA_W'(empty ? last.ins : head.ins);

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst)                                                   misalign_q <= 1'b0;
    else if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
  end
  assign stopped          = misalign_q;
  assign bus.misalign_err = misalign_q;
`else
  assign stopped          = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) assert (count <= CNT_W'(DEPTH));
  end
endmodule

// File: tb/tb_ins_fetch_unit.sv
// Randomized bench for ins_fetch_unit against a queue-based fetch model.
module tb_ins_fetch_unit;
  localparam int          ADDR_W   = 10;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [1024];
  ent_t        q [$];
  logic [31:0] m_pc;
  ent_t        m_last;
  logic        m_err;

  ins_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ins_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.im_data = mem[bus.im_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rp,
                       input logic h, input logic rdy);
    ent_t exp;
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.halt           = h;
    bus.out_ready      = rdy;
    if (r) begin
      q.delete();
      m_pc   = RESET_PC;
      m_last = '0;
      m_err  = 1'b0;
    end else if (rv) begin
      q.delete();
      m_pc = {rp[31:2], 2'b00};
`ifdef IFU_MISALIGN_CHK_EN
      if (rp[1:0] != 2'b00) m_err = 1'b1;
`endif
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (!h && !m_err && q.size() < DEPTH) begin
        q.push_back('{pc: m_pc, ins: mem[m_pc[11:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    exp = (q.size() > 0) ? q[0] : m_last;
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("im_addr", bus.im_addr, m_pc[11:2]);
    chk("out_pc", bus.out_pc, exp.pc);
    chk("out_ins", bus.out_ins, exp.ins);
    chk("misalign_err", bus.misalign_err, m_err);
    m_last = exp;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    bus.out_ready      = 1'b0;
    m_pc = RESET_PC; m_last = '0; m_err = 1'b0;

    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_pc", bus.out_pc, 32'h0);

    // sequential fetch, back-to-back drain
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);
    // backpressure saturates then drains
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    // redirect while full
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h40, 0, 0);
    chk("redir_v0", bus.out_valid, 1'b0);
    cycle(0, 0, 0, 0, 1);
    chk("redir_pc", bus.out_pc, 32'h40);
    chk("redir_ins", bus.out_ins, mem[16]);
    // top-of-memory wrap
    cycle(0, 1, 32'hFFC, 0, 1);
    chk("wrap_a0", bus.im_addr, 10'd1023);
    cycle(0, 0, 0, 0, 1);
    chk("wrap_pc0", bus.out_pc, 32'hFFC);
    chk("wrap_a1", bus.im_addr, 10'd0);
    cycle(0, 0, 0, 0, 1);
    chk("wrap_pc1", bus.out_pc, 32'h1000);
    // halt drains then resumes
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("halt_empty", bus.out_valid, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = $urandom;
`ifdef IFU_MISALIGN_CHK_EN
      rp[1:0] = 2'b00;
`endif
      cycle(($urandom_range(199) == 0), ($urandom_range(19) == 0), rp,
            ($urandom_range(9) == 0), ($urandom_range(3) != 0));
    end

`ifdef IFU_MISALIGN_CHK_EN
    cycle(0, 1, 32'h42, 0, 1);
    chk("mis_set", bus.misalign_err, 1'b1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    chk("mis_stop", bus.out_valid, 1'b0);
    cycle(1, 0, 0, 0, 1);
    chk("mis_clr", bus.misalign_err, 1'b0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
`else
    cycle(0, 1, 32'h42, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("mis_clear_pc", bus.out_pc, 32'h40);
    chk("mis_flag0", bus.misalign_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
